// File: rtl/div_16bit_issue.sv
// ---------------------------------------------------------------------------
// div_16bit_issue
//   Issue/retire stage wrapped around a combinational 16-bit divider.
//   Operand pairs are queued behind a valid/ready handshake. The head entry
//   drives the divider. Quotient and remainder are captured into a registered
//   valid/ready output stage. One divide per cycle is sustained while the
//   consumer keeps out_ready high. Results retire in strict acceptance order.
//
// Parameters
//   DEPTH  operand queue entries (power of 2, >= 2)
//   AW     pointer width, log2(DEPTH)
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand pair offered
//   in_ready   out  queue can accept (not full)
//   in_a       in   dividend
//   in_b       in   divisor
//   div_a      out  head dividend to divider (0 when queue empty)
//   div_b      out  head divisor to divider (0 when queue empty)
//   div_q      in   divider quotient (combinational)
//   div_r      in   divider remainder (combinational)
//   out_valid  out  result register holds a valid result
//   out_ready  in   consumer accepts result
//   out_q      out  registered quotient
//   out_r      out  registered remainder
//   level      out  queue occupancy, 0..DEPTH
//   out_dz     out  divide-by-zero flag (only with DIV_ZERO_TRAP_EN)
//
// Build option
//   DIV_ZERO_TRAP_EN  when defined, a pop of an entry with divisor 0 yields
//                     q=0, r=0 and raises out_dz; the divider outputs are
//                     ignored for that entry. When undefined, the divider's
//                     own b==0 result passes through and out_dz is absent.
// ---------------------------------------------------------------------------
module div_16bit_issue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_a,
  input  logic [15:0]   in_b,
  output logic [15:0]   div_a,
  output logic [15:0]   div_b,
  input  logic [15:0]   div_q,
  input  logic [15:0]   div_r,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_q,
  output logic [15:0]   out_r,
  output logic [AW:0]   level
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic          out_dz
`endif
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [15:0]   mem_a [DEPTH];
  logic [15:0]   mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [15:0]   head_a;
  logic [15:0]   head_b;

  // Full is judged on the registered level only: a pop in the same cycle
  // does not open a slot for the producer until the next cycle.
  always_comb begin
    empty    = (count == '0);
    full     = (count == FULL_LEVEL);
    in_ready = !full;
    push     = in_valid && !full;
    pop      = !empty && (!out_valid || out_ready);
    head_a   = mem_a[rd_ptr];
    head_b   = mem_b[rd_ptr];
    div_a    = empty ? '0 : head_a;
    div_b    = empty ? '0 : head_b;
    level    = count;
  end

  // Queue storage needs no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_dz    <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      if (head_b == '0) begin
        out_q  <= '0;
        out_r  <= '0;
        out_dz <= 1'b1;
      end else begin
        out_q  <= div_q;
        out_r  <= div_r;
        out_dz <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_q     <= div_q;
      out_r     <= div_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_div_16bit_issue.sv
module tb_div_16bit_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] div_a;
  logic [15:0] div_b;
  logic [15:0] div_q;
  logic [15:0] div_r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_q;
  logic [15:0] out_r;
  logic [2:0]  level;
  logic        out_dz;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Expected results in acceptance order: {dz, q, r}
  logic [32:0] sb[$];

  int xfer_cnt   = 0;
  int first_xfer = -1;
  int last_xfer  = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_16bit_issue #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
    .level(level)
`ifdef DIV_ZERO_TRAP_EN
    , .out_dz(out_dz)
`endif
  );

`ifndef DIV_ZERO_TRAP_EN
  assign out_dz = 1'b0;
`endif

  // Environment: combinational divider the stage feeds.
  always_comb begin
    div_q = 16'hFFFF;
    div_r = div_a;
    if (div_b != 16'd0) begin
      div_q = div_a / div_b;
      div_r = div_a % div_b;
    end
  end

  function automatic logic [32:0] ref_result(input logic [15:0] a, input logic [15:0] b);
    int unsigned ai = a;
    int unsigned bi = b;
`ifdef DIV_ZERO_TRAP_EN
    if (bi == 0) return {1'b1, 16'h0000, 16'h0000};
`else
    if (bi == 0) return {1'b0, 16'hFFFF, a};
`endif
    return {1'b0, 16'(ai / bi), 16'(ai % bi)};
  endfunction

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard + monitor. Inputs change only #1 after posedge, so values seen
  // at the negedge are the ones the DUT samples on the following posedge.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", {out_dz, out_q, out_r}, 33'h0);
          n_err += (out_q == 0 && out_r == 0 && out_dz == 0) ? 1 : 0;
        end else begin
          chk("result", {out_dz, out_q, out_r}, sb[0]);
          if (out_ready) begin
            void'(sb.pop_front());
            xfer_cnt++;
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(ref_result(in_a, in_b));
    end
  end

  task automatic offer(input logic [15:0] a, input logic [15:0] b, output bit ok);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input string name, input logic [15:0] a, input logic [15:0] b);
    bit ok;
    offer(a, b, ok);
    if (!ok) chk({name, "_accept_timeout"}, 33'd0, 33'd1);
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid && level == 0) done = 1'b1;
    end
    chk({name, "_drained"}, 33'(done), 33'd1);
    @(posedge clk); #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; in_valid = 1'b1; in_a = 16'd55; in_b = 16'd5; out_ready = 1'b0;

    // Reset with a pair offered throughout: nothing must be queued.
    tick(2);
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst_out_valid", 33'(out_valid), 33'd0);
    chk("rst_level", 33'(level), 33'd0);
    chk("rst_in_ready", 33'(in_ready), 33'd1);
    chk("rst_out_qr", {out_dz, out_q, out_r}, 33'd0);
    chk("rst_div_ab", {1'b0, div_a, div_b}, 33'd0);
    tick(2);
    chk("rst_nothing_queued", {30'd0, out_valid, level}, 33'd0);

    // Single op: accepted at edge N, popped into the output register at
    // edge N+1, so the consumer first samples out_valid at edge N+2.
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'd100; in_b = 16'd7;
    tick(1);
    in_valid = 1'b0;
    chk("lat_after_N_valid", 33'(out_valid), 33'd0);
    chk("lat_after_N_level", 33'(level), 33'd1);
    chk("lat_head_ab", {1'b0, div_a, div_b}, {1'b0, 16'd100, 16'd7});
    tick(1);
    chk("lat_after_N1_valid", 33'(out_valid), 33'd1);
    chk("single_qr", {1'b0, out_q, out_r}, {1'b0, 16'd14, 16'd2});
    chk("single_level", 33'(level), 33'd0);
    drain("single");

    // Backpressure: 1 held in output register + 4 queued, then a 6th stalls.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send("bp", 16'(3000 + 17*i), 16'(i + 3));
    tick(1);
    chk("bp_level_full", 33'(level), 33'd4);
    chk("bp_in_ready_low", 33'(in_ready), 33'd0);
    chk("bp_out_valid", 33'(out_valid), 33'd1);
    in_valid = 1'b1; in_a = 16'd65535; in_b = 16'd256;
    tick(5);
    chk("bp_stall_ready", 33'(in_ready), 33'd0);
    chk("bp_stall_level", 33'(level), 33'd4);
    chk("bp_sb_count", 33'(sb.size()), 33'd5);
    out_ready = 1'b1;
    // The first pop while full must not admit the stalled pair the same edge.
    @(negedge clk);
    chk("bp_no_full_bypass", 33'(in_ready), 33'd0);
    @(posedge clk); #1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_sixth_accepted", 33'(ok), 33'd1);
    drain("bp");

    // Streaming: one result per cycle with out_ready held high.
    xfer_cnt = 0; first_xfer = -1; last_xfer = -1;
    for (int i = 0; i < 16; i++) send("stream", 16'(i * 1000), 16'(i + 1));
    drain("stream");
    chk("stream_count", 33'(xfer_cnt), 33'd16);
    chk("stream_span", 33'(last_xfer - first_xfer), 33'd15);

    // Divide by zero.
    send("dz", 16'd1234, 16'd0);
    drain("dz");

    // Mid-operation reset: held result + 3 queued are discarded.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send("mid", 16'(500 + i), 16'(i + 2));
    tick(1);
    chk("mid_pre_valid", 33'(out_valid), 33'd1);
    chk("mid_pre_level", 33'(level), 33'd3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mid_rst_valid", 33'(out_valid), 33'd0);
    chk("mid_rst_level", 33'(level), 33'd0);
    chk("mid_rst_in_ready", 33'(in_ready), 33'd1);
    out_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (out_valid) ok = 1'b1;
    end
    chk("mid_no_stale", 33'(ok), 33'd0);

    // Randomized traffic with random backpressure.
    begin
      bit acc;
      in_valid = 1'b0;
      for (int k = 0; k < 500; k++) begin
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
        if (acc || !in_valid) begin
          in_valid = ($urandom_range(0, 2) != 0);
          in_a = 16'($urandom);
          case ($urandom_range(0, 7))
            0:       in_b = 16'd0;
            1, 2, 3: in_b = 16'($urandom_range(1, 15));
            default: in_b = 16'($urandom);
          endcase
        end
      end
      // Let any pending offer complete before stopping.
      ok = !in_valid;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge clk);
        if (in_ready) ok = 1'b1;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("rand_last_accept", 33'(ok), 33'd1);
      drain("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
